button_debounce: RTL and testbench



---
 rtl/button_debounce.sv | 141 ++++++++++++++
 tb/tb_button_debounce.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Per-channel push-button debouncer: 2-FF synchroniser, 4-state FSM and qualification counter.
// Define DEBOUNCE_HOLD_EN to add the long-press `hold` output and its per-channel hold counter.
module button_debounce #(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned HOLD_CYCLES     = 50000000
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] pending
`ifdef DEBOUNCE_HOLD_EN
    ,
    output logic [WIDTH-1:0] hold
`endif
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        PEND_HIGH,
        STABLE_HIGH,
        PEND_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject configurations where the counter would wrap or qualification degenerates.
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 ||
        (CNT_W < 32 && (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES))) begin : g_bad_param
        $error("button_debounce: invalid parameter combination");
    end

`ifdef DEBOUNCE_HOLD_EN
    localparam int unsigned        HCNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCNT_W-1:0]  HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [HCNT_W-1:0]  HOLD_MAX  = HCNT_W'(HOLD_CYCLES);
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic             r_s1;
        logic             r_s2;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_out;
        logic             w_out_nxt;

        always_ff @(posedge clk) begin
            if (r) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_state <= STABLE_LOW;
                r_cnt   <= '0;
                r_out   <= 1'b0;
            end else begin
                r_s1    <= in[i];
                r_s2    <= r_s1;
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_out   <= w_out_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = '0;
            w_out_nxt   = r_out;
            case (r_state)
                STABLE_LOW: begin
                    if (r_s2) begin
                        w_state_nxt = PEND_HIGH;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                PEND_HIGH: begin
                    if (!r_s2) begin
                        w_state_nxt = STABLE_LOW;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_HIGH;
                        w_out_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!r_s2) begin
                        w_state_nxt = PEND_LOW;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                PEND_LOW: begin
                    if (r_s2) begin
                        w_state_nxt = STABLE_HIGH;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_LOW;
                        w_out_nxt   = 1'b0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = STABLE_LOW;
                    w_out_nxt   = 1'b0;
                end
            endcase
        end

        assign out[i]     = r_out;
        assign pending[i] = (r_state == PEND_HIGH) || (r_state == PEND_LOW);

`ifdef DEBOUNCE_HOLD_EN
        logic [HCNT_W-1:0] r_hcnt;
        logic              r_hold;
        logic              w_stay_high;

        // Counting stops the moment release qualification starts, so hold drops with pending rising.
        assign w_stay_high = (r_state == STABLE_HIGH) && r_s2;

        always_ff @(posedge clk) begin
            if (r || !w_stay_high) begin
                r_hcnt <= '0;
                r_hold <= 1'b0;
            end else begin
                if (r_hcnt == HOLD_LAST) begin
                    r_hold <= 1'b1;
                end
                if (r_hcnt != HOLD_MAX) begin
                    r_hcnt <= r_hcnt + HCNT_W'(1);
                end
            end
        end

        assign hold[i] = r_hold;
`endif
    end

endmodule

// File: tb/tb_button_debounce.sv
// Randomised and directed bench for button_debounce against a run-length reference model.
// Hold checks are active when DEBOUNCE_HOLD_EN is defined.
module tb_button_debounce;

    localparam int W  = 2;
    localparam int D  = 4;
    localparam int HC = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] btn;
    logic [W-1:0] dout;
    logic [W-1:0] dpend;
`ifdef DEBOUNCE_HOLD_EN
    logic [W-1:0] dhold;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: synchroniser pipeline, accepted level, run of disagreeing samples, high-stable age.
    int m_s1[W];
    int m_s2[W];
    int m_out[W];
    int m_run[W];
    int m_age[W];

    always #5 clk = ~clk;

    button_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk    (clk),
        .r      (rst),
        .in     (btn),
        .out    (dout),
        .pending(dpend)
`ifdef DEBOUNCE_HOLD_EN
        ,
        .hold   (dhold)
`endif
    );

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < W; c++) begin
            if (rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_run[c] = 0; m_age[c] = 0;
            end else begin
                if (m_s2[c] != m_out[c]) begin
                    m_age[c] = 0;
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_out[c] = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    if (m_out[c] == 1 && m_run[c] == 0)
                        m_age[c] = (m_age[c] < HC) ? m_age[c] + 1 : HC;
                    else
                        m_age[c] = 0;
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = int'(btn[c]);
            end
        end
    endtask

    task automatic cyc(input logic rr, input logic [W-1:0] b);
        logic [W-1:0] e_out, e_pend, e_hold;
        @(negedge clk);
        rst = rr;
        btn = b;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < W; c++) begin
            e_out[c]  = (m_out[c] != 0);
            e_pend[c] = (m_run[c] > 0);
            e_hold[c] = (m_age[c] >= HC);
        end
        check_val("out", dout, e_out);
        check_val("pending", dpend, e_pend);
`ifdef DEBOUNCE_HOLD_EN
        check_val("hold", dhold, e_hold);
`endif
    endtask

    int rise_at;
    int left[W];
    logic [W-1:0] rb;

    initial begin
        rst = 1'b1;
        btn = '0;
        for (int c = 0; c < W; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_run[c] = 0; m_age[c] = 0;
        end

        // Reset with both buttons pressed, then a clean press on channel 0.
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 2'b11);
            check_val("rst_out", dout, 2'b00);
            check_val("rst_pend", dpend, 2'b00);
        end
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, 2'b01);
            check_val("press_latency", {1'b0, dout[0]}, {1'b0, (j >= D + 1)});
            check_val("press_pend", {1'b0, dpend[0]}, {1'b0, (j >= 2 && j <= D)});
        end
        for (int j = 0; j < 8; j++) cyc(1'b0, 2'b00);

        // Bounce rejection.
        cyc(1'b0, 2'b01); cyc(1'b0, 2'b00); cyc(1'b0, 2'b01); cyc(1'b0, 2'b00);
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, 2'b00);
            check_val("bounce_out", dout, 2'b00);
        end

        // Late glitch: only the final run of highs may qualify.
        for (int j = 0; j < 3; j++) cyc(1'b0, 2'b01);
        cyc(1'b0, 2'b00);
        for (int j = 0; j < 6; j++) begin
            cyc(1'b0, 2'b01);
            check_val("late_glitch", {1'b0, dout[0]}, {1'b0, (j >= D + 1)});
        end

        // Channel 1 pressed 2 cycles after channel 0 qualified, then channel 0 released.
        cyc(1'b0, 2'b01);
        rise_at = -1;
        for (int j = 0; j < 10; j++) begin
            cyc(1'b0, 2'b11);
            if (dout[1] && rise_at < 0) rise_at = j;
        end
        check_val("ch1_rise_edge", 2'(rise_at), 2'(D + 1));
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, 2'b10);
            check_val("release_indep", dout, {1'b1, (j < D + 1)});
        end
        for (int j = 0; j < 8; j++) cyc(1'b0, 2'b00);

        // Reset mid-qualification while held.
        for (int j = 0; j < 4; j++) cyc(1'b0, 2'b01);
        cyc(1'b1, 2'b01);
        check_val("midrst", {dout[0], dpend[0]}, 2'b00);
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, 2'b01);
            check_val("requalify", {1'b0, dout[0]}, {1'b0, (j >= D + 1)});
        end

        // Long press then release.
        for (int j = 0; j < 16; j++) cyc(1'b0, 2'b01);
        for (int j = 0; j < 8; j++) cyc(1'b0, 2'b00);

        // Randomised run lengths per channel with occasional resets.
        for (int c = 0; c < W; c++) left[c] = 1;
        rb = '0;
        for (int j = 0; j < 1500; j++) begin
            for (int c = 0; c < W; c++) begin
                left[c]--;
                if (left[c] <= 0) begin
                    rb[c] = ~rb[c];
                    left[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(3, 18));
                end
            end
            cyc(($urandom_range(0, 199) == 0), rb);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
